// File: rtl/rs_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : rs_pulse_gen
//  Purpose  : Drives the active-low set/reset inputs of a cross-coupled NAND
//             RS latch. Each single-cycle request becomes one registered,
//             glitch-free low pulse of PW cycles on s_n or r_n, followed by
//             GAP cycles of dead time. s_n and r_n are never low together.
//  Options  : `define RS_READBACK_EN to synchronise q_fb and check it against
//             the requested operation. This raises a sticky err flag.
//  Revision : 1.0  initial release
// ============================================================================
module rs_pulse_gen #(
    parameter int PW  = 4,   // pulse width in cycles, 1..255
    parameter int GAP = 2    // dead time after each pulse, 0..255
) (
    input  logic clk,
    input  logic clrn,
    input  logic set_req,
    input  logic rst_req,
    input  logic q_fb,
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_pulse = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    localparam logic [7:0] c_pw_load  = 8'(PW - 1);
    // When GAP is 0 the gap state is skipped, so this value is never loaded.
    localparam logic [7:0] c_gap_load = 8'(GAP - 1);

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic       r_op;      // 1 = set operation, 0 = reset operation
    logic       w_accept;

    // Requests are only taken from IDLE. While busy, requests are dropped rather than queued.
    assign w_accept = (r_state == c_st_idle) && (set_req || rst_req);

    // Sequencer: the latch outputs are registered here, so they never glitch.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_st_idle;
            r_cnt   <= 8'd0;
            r_op    <= 1'b0;
            s_n     <= 1'b1;
            r_n     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        // Reset wins a simultaneous request. The set request is discarded.
                        r_state <= c_st_pulse;
                        r_op    <= ~rst_req;
                        r_cnt   <= c_pw_load;
                        busy    <= 1'b1;
                        s_n     <= rst_req;
                        r_n     <= ~rst_req;
                    end
                end
                c_st_pulse: begin
                    if (r_cnt == 8'd0) begin
                        s_n <= 1'b1;
                        r_n <= 1'b1;
                        if (GAP == 0) begin
                            r_state <= c_st_idle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= c_st_gap;
                            r_cnt   <= c_gap_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                        s_n   <= ~r_op;
                        r_n   <= r_op;
                    end
                end
                c_st_gap: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= c_st_idle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= 8'd0;
                    s_n     <= 1'b1;
                    r_n     <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RS_READBACK_EN
    logic [1:0] r_sync;
    logic       r_err;

    // The latch output is asynchronous to clk, so it goes through two flops before use.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], q_fb};
        end
    end

    // Sticky mismatch flag. It is checked in the done cycle and cleared by the next accepted request.
    // If a mismatch and a new acceptance fall in the same cycle, the mismatch is kept so it is not lost.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_err <= 1'b0;
        end else if (done && (r_sync[1] != r_op)) begin
            r_err <= 1'b1;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;

    // The dead time must cover the synchroniser latency before the done-cycle compare.
    generate
        if (GAP < 2) begin : g_gap_check
            $error("rs_pulse_gen: GAP must be >= 2 when RS_READBACK_EN is defined");
        end
    endgenerate
`else
    logic w_unused_q_fb;

    assign w_unused_q_fb = q_fb;
    assign err           = 1'b0;
`endif

endmodule
`default_nettype wire
